// File: rtl/activation_bank_reader.sv
// ---------------------------------------------------------------------------
// activation_bank_reader
//
// Reads one activation word from each of z banks in parallel. Every accepted
// address package therefore produces a z-word output beat. The beats are
// returned under valid/ready flow control. The final beat of each fo*p/z
// sweep is tagged with out_last. A separate write port loads the previous
// layer's activations into the banks.
//
// Pipeline:
//   accept (edge E0) -> stage A holds the lane addresses
//   edge E1          -> banks are read (write-first) and the beat is pushed
//                       into a 3-deep output queue
//   The queue is built from the output register plus a 2-entry skid buffer.
//   This lets out_data hold its last value while the queue is empty.
//
// Flow control:
//   An occupancy counter tracks stage-A entries plus queue entries.
//   in_ready is registered from the next value of that counter, so there is
//   no combinational path from out_ready to in_ready. With occupancy capped
//   at 3, stage A can always push at E1 and never stalls.
//
// Ports:
//   clk             clock
//   reset_n         asynchronous active-low reset
//   clear           synchronous flush of in-flight reads and the sweep count
//   in_valid        address package valid
//   in_ready        block can accept an address package
//   address_package lane i address at [i*AW +: AW]; lane i reads bank i
//   wr_en           activation write strobe
//   wr_bank         bank to write
//   wr_addr         word within the bank
//   wr_data         activation value
//   out_valid       read data valid
//   out_ready       consumer accepts the data
//   out_data        lane i data at [i*W +: W]
//   out_last        beat is the last of a sweep
// ---------------------------------------------------------------------------
module activation_bank_reader #(
  parameter int fo = 2,
  parameter int p  = 16,
  parameter int z  = 8,
  parameter int W  = 16,
  localparam int AW = $clog2(p / z),
  localparam int BW = $clog2(z)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW*z-1:0] address_package,
  input  logic            wr_en,
  input  logic [BW-1:0]   wr_bank,
  input  logic [AW-1:0]   wr_addr,
  input  logic [W-1:0]    wr_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W*z-1:0]  out_data,
  output logic            out_last
);

  localparam int DEPTH = p / z;
  localparam int SWEEP = fo * p / z;
  localparam int SW    = $clog2(SWEEP);

  // Activation storage. This is deliberately not reset.
  logic [W-1:0]   bank_r [z][DEPTH];

  // Stage A: the registered address package and its sweep tag.
  logic           a_valid_r;
  logic [AW*z-1:0] a_addr_r;
  logic           a_last_r;

  // Output register (queue head) plus the 2-entry skid buffer behind it.
  logic           out_valid_r;
  logic [W*z-1:0] out_data_r;
  logic           out_last_r;
  logic [W*z-1:0] buf_data_r [2];
  logic           buf_last_r [2];
  logic [1:0]     buf_cnt_r;

  // Credit and sweep state.
  logic [1:0]     occ_r;
  logic           in_ready_r;
  logic [SW-1:0]  sweep_r;

  // Combinational next-state values.
  logic           acc_s;
  logic           pop_s;
  logic           push_s;
  logic           slot_free_s;
  logic [W*z-1:0] rd_data_s;
  logic [1:0]     occ_n_s;
  logic           out_valid_n_s;
  logic [W*z-1:0] out_data_n_s;
  logic           out_last_n_s;
  logic [W*z-1:0] buf_data_n_s [2];
  logic           buf_last_n_s [2];
  logic [1:0]     buf_cnt_n_s;
  logic           sweep_end_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;

  // Handshake qualifiers. A clear cycle suppresses every handshake.
  always_comb begin
    acc_s       = in_valid & in_ready_r & ~clear;
    pop_s       = out_valid_r & out_ready & ~clear;
    push_s      = a_valid_r & ~clear;
    slot_free_s = ~out_valid_r | pop_s;
    sweep_end_s = (sweep_r == SW'(SWEEP - 1));
  end

  // Bank write port. Writes are taken on every edge, including clear cycles.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_r[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Parallel lane read. A same-edge write to the same word is forwarded.
  always_comb begin
    rd_data_s = {(W*z){1'b0}};
    for (int i = 0; i < z; i++) begin
      if (wr_en && (wr_bank == BW'(i)) && (wr_addr == a_addr_r[i*AW +: AW])) begin
        rd_data_s[i*W +: W] = wr_data;
      end else begin
        rd_data_s[i*W +: W] = bank_r[i][a_addr_r[i*AW +: AW]];
      end
    end
  end

  // Occupancy next value: +1 on accept, -1 on pop, and cleared by clear.
  always_comb begin
    occ_n_s = occ_r;
    if (clear) begin
      occ_n_s = 2'd0;
    end else begin
      case ({acc_s, pop_s})
        2'b10:   occ_n_s = occ_r + 2'd1;
        2'b01:   occ_n_s = occ_r - 2'd1;
        default: occ_n_s = occ_r;
      endcase
    end
  end

  // Output queue next state. The head refills from the skid buffer first,
  // so beats leave in the order they were accepted. Occupancy is capped at 3,
  // so the buffer never overflows.
  always_comb begin
    out_valid_n_s = out_valid_r;
    out_data_n_s  = out_data_r;
    out_last_n_s  = out_last_r;
    buf_data_n_s  = buf_data_r;
    buf_last_n_s  = buf_last_r;
    buf_cnt_n_s   = buf_cnt_r;
    if (clear) begin
      out_valid_n_s = 1'b0;
      buf_cnt_n_s   = 2'd0;
    end else if (slot_free_s) begin
      if (buf_cnt_r != 2'd0) begin
        out_valid_n_s   = 1'b1;
        out_data_n_s    = buf_data_r[0];
        out_last_n_s    = buf_last_r[0];
        buf_data_n_s[0] = buf_data_r[1];
        buf_last_n_s[0] = buf_last_r[1];
        if (push_s) begin
          // After the shift, the tail slot is buf_cnt_r-1. That is bit 1 for cnt 1..2.
          buf_data_n_s[buf_cnt_r[1]] = rd_data_s;
          buf_last_n_s[buf_cnt_r[1]] = a_last_r;
        end else begin
          buf_cnt_n_s = buf_cnt_r - 2'd1;
        end
      end else if (push_s) begin
        out_valid_n_s = 1'b1;
        out_data_n_s  = rd_data_s;
        out_last_n_s  = a_last_r;
      end else begin
        out_valid_n_s = 1'b0;
      end
    end else if (push_s) begin
      buf_data_n_s[buf_cnt_r[0]] = rd_data_s;
      buf_last_n_s[buf_cnt_r[0]] = a_last_r;
      buf_cnt_n_s                = buf_cnt_r + 2'd1;
    end else begin
      buf_cnt_n_s = buf_cnt_r;
    end
  end

  // Stage A, sweep counter and credit registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid_r  <= 1'b0;
      a_addr_r   <= {(AW*z){1'b0}};
      a_last_r   <= 1'b0;
      occ_r      <= 2'd0;
      in_ready_r <= 1'b1;
      sweep_r    <= {SW{1'b0}};
    end else begin
      a_valid_r  <= acc_s;
      occ_r      <= occ_n_s;
      in_ready_r <= (occ_n_s != 2'd3);
      if (acc_s) begin
        a_addr_r <= address_package;
        a_last_r <= sweep_end_s;
      end
      if (clear) begin
        sweep_r <= {SW{1'b0}};
      end else if (acc_s) begin
        sweep_r <= sweep_end_s ? {SW{1'b0}} : sweep_r + SW'(1);
      end
    end
  end

  // Output register and skid buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r   <= 1'b0;
      out_data_r    <= {(W*z){1'b0}};
      out_last_r    <= 1'b0;
      buf_data_r[0] <= {(W*z){1'b0}};
      buf_data_r[1] <= {(W*z){1'b0}};
      buf_last_r[0] <= 1'b0;
      buf_last_r[1] <= 1'b0;
      buf_cnt_r     <= 2'd0;
    end else begin
      out_valid_r <= out_valid_n_s;
      out_data_r  <= out_data_n_s;
      out_last_r  <= out_last_n_s;
      buf_data_r  <= buf_data_n_s;
      buf_last_r  <= buf_last_n_s;
      buf_cnt_r   <= buf_cnt_n_s;
    end
  end

endmodule

// File: tb/tb_activation_bank_reader.sv
// ---------------------------------------------------------------------------
// Testbench for activation_bank_reader (fo=2, p=16, z=8, W=16).
// The stimulus pushes the expected beat {data, last} into a queue when an
// accept is seen. The monitor pops from the queue and compares whenever the
// DUT hands over a beat.
// ---------------------------------------------------------------------------
module tb_activation_bank_reader;

  logic         clk;
  logic         reset_n;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   address_package;
  logic         wr_en;
  logic [2:0]   wr_bank;
  logic [0:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;

  int tests = 0;
  int fails = 0;
  int beats = 0;
  int sw_model = 0;

  logic [15:0]  exp_mem [8][2];
  logic [128:0] exp_q [$];

  logic [7:0] tp_pkgs [8] = '{8'h00, 8'hFF, 8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h3C, 8'hC3};
  logic [7:0] bp_pkgs [5] = '{8'h01, 8'h02, 8'h04, 8'h80, 8'h40};

  activation_bank_reader #(.fo(2), .p(16), .z(8), .W(16)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .address_package(address_package),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compute the expected beat for this package from the bench's bank image.
  task automatic push_exp(input logic [7:0] pkg);
    logic [127:0] d;
    for (int i = 0; i < 8; i++) d[i*16 +: 16] = exp_mem[i][pkg[i]];
    exp_q.push_back({d, (sw_model == 3)});
    sw_model = (sw_model + 1) % 4;
  endtask

  task automatic write_word(input int b, input int a, input logic [15:0] v);
    wr_en = 1'b1; wr_bank = 3'(b); wr_addr = 1'(a); wr_data = v;
    exp_mem[b][a] = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Hold in_valid until accepted (bounded). This leaves in_valid high on return.
  task automatic send(input logic [7:0] pkg);
    int waited = 0;
    in_valid = 1'b1;
    address_package = pkg;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", {127'd0, in_ready}, 128'd1);
    if (in_ready) push_exp(pkg);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || out_valid) && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  // Monitor: score every transferred beat and check that data stays stable under backpressure.
  initial begin
    logic [128:0] e;
    logic         hold_v;
    logic [127:0] hold_d;
    logic         hold_l;
    hold_v = 1'b0;
    hold_d = 128'd0;
    hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && !clear) begin
        if (out_valid && out_ready) begin
          beats++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got %h expected no beat", out_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", out_data, e[128:1]);
            check("beat_last", {127'd0, out_last}, {127'd0, e[0]});
          end
          hold_v = 1'b0;
        end else if (out_valid) begin
          if (hold_v) begin
            check("hold_data", out_data, hold_d);
            check("hold_last", {127'd0, out_last}, {127'd0, hold_l});
          end
          hold_v = 1'b1;
          hold_d = out_data;
          hold_l = out_last;
        end else begin
          hold_v = 1'b0;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int start_beats;
    int waited;
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; address_package = 8'd0;
    wr_en = 1'b0; wr_bank = 3'd0; wr_addr = 1'b0; wr_data = 16'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_last", {127'd0, out_last}, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;

    // Load bank i word j = 0x0100*i + j.
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 2; a++)
        write_word(b, a, 16'(16'h0100 * b + a));

    // Throughput: 8 back-to-back accepts; out_last on beats 4 and 8.
    out_ready = 1'b1;
    start_beats = beats;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      address_package = tp_pkgs[k];
      @(negedge clk);
      check("tp_in_ready", {127'd0, in_ready}, 128'd1);
      if (in_ready) push_exp(tp_pkgs[k]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("tp_beat_count", 128'(beats - start_beats), 128'd8);
    drain();

    // Load and read with the two-cycle latency.
    send(8'hAA);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_t1_idle", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    check("lat_t2_valid", {127'd0, out_valid}, 128'd1);
    check("lat_lane5", {112'd0, out_data[5*16 +: 16]}, 128'h0501);
    check("lat_lane4", {112'd0, out_data[4*16 +: 16]}, 128'h0400);
    drain();

    // Backpressure: exactly 3 accepts while out_ready is low.
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    address_package = bp_pkgs[0];
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(bp_pkgs[acc]);
        acc++;
      end
      @(posedge clk); #1;
      address_package = bp_pkgs[acc < 5 ? acc : 4];
    end
    check("bp_accepts", 128'(acc), 128'd3);
    check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
    out_ready = 1'b1;
    waited = 0;
    while (acc < 5 && waited < 20) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(bp_pkgs[acc]);
        acc++;
      end
      @(posedge clk); #1;
      address_package = bp_pkgs[acc < 5 ? acc : 4];
      waited++;
    end
    check("bp_resume", 128'(acc), 128'd5);
    in_valid = 1'b0;
    drain();

    // Write-first hazard: bank 5 word 0 is written on the read edge.
    exp_mem[5][0] = 16'hBEEF;
    send(8'h00);
    in_valid = 1'b0;
    wr_en = 1'b1; wr_bank = 3'd5; wr_addr = 1'b0; wr_data = 16'hBEEF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    send(8'h00);
    in_valid = 1'b0;
    drain();

    // Clear with two reads in flight.
    out_ready = 1'b0;
    send(8'h11);
    send(8'h22);
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
    sw_model = 0;
    @(negedge clk);
    check("clr_out_valid", {127'd0, out_valid}, 128'd0);
    check("clr_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h81);
    send(8'h42);
    send(8'h24);
    send(8'h18);
    in_valid = 1'b0;
    drain();

    // Reset mid-stream.
    send(8'h33);
    send(8'h44);
    in_valid = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    sw_model = 0;
    @(negedge clk);
    check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst_out_data", out_data, 128'd0);
    check("mid_rst_out_last", {127'd0, out_last}, 128'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("post_rst_out_valid", {127'd0, out_valid}, 128'd0);
    @(posedge clk); #1;
    send(8'h5A);
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
